// File: rtl/mux_stim_gen_if.sv
// Bundles the mux stimulus signals: controls into the generator, mux data/select out of it.
interface mux_stim_gen_if;
    logic en;
    logic mode;
    logic btn_raw;
    logic in_a;
    logic in_b;
    logic sel;
    logic sel_changed;

    modport master (
        input  en, mode, btn_raw,
        output in_a, in_b, sel, sel_changed
    );

    modport slave (
        output en, mode, btn_raw,
        input  in_a, in_b, sel, sel_changed
    );
endinterface

// File: rtl/mux_stim_gen.sv
// Square-wave data sources and select generator for a 2:1 mux.
// Select is either auto-toggled by a divider or toggled by a debounced push-button.
module mux_stim_gen #(
    parameter int CNT_W     = 16,
    parameter int DIV_A     = 10,
    parameter int DIV_B     = 50,
    parameter int DIV_SEL   = 200,
    parameter int DB_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_stim_gen_if.master bus
);
    localparam logic [CNT_W-1:0] SEL_TERM = CNT_W'(DIV_SEL - 1);
    localparam logic [CNT_W-1:0] DB_TERM  = CNT_W'(DB_CYCLES - 1);

    // Data dividers: g_div[0] drives in_a, g_div[1] drives in_b.
    for (genvar gi = 0; gi < 2; gi++) begin : g_div
        localparam int               DIV  = (gi == 0) ? DIV_A : DIV_B;
        localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             out_q, out_d;

        always_comb begin
            cnt_d = cnt_q;
            out_d = out_q;
            if (bus.en) begin
                if (cnt_q == TERM) begin
                    cnt_d = '0;
                    out_d = ~out_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                out_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                out_q <= out_d;
            end
        end
    end

    assign bus.in_a = g_div[0].out_q;
    assign bus.in_b = g_div[1].out_q;

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             db_q, db_d;
    logic             db_dly_q;
    logic             db_rise;
    logic             sync2;

    assign sync_d  = {sync_q[0], bus.btn_raw};
    assign sync2   = sync_q[1];
    // Rise is taken from the registered debounced level, one edge after acceptance.
    assign db_rise = db_q & ~db_dly_q;

    always_comb begin
        db_cnt_d = db_cnt_q;
        db_d     = db_q;
        if (sync2 == db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_TERM) begin
            db_d     = sync2;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    logic [CNT_W-1:0] sel_cnt_q, sel_cnt_d;
    logic             mode_q;
    logic             sel_q, sel_d;
    logic             sel_changed_q;
    logic             sel_tog;
    logic             mode_chg;

    assign mode_chg = (bus.mode != mode_q);

    always_comb begin
        sel_cnt_d = sel_cnt_q;
        sel_tog   = 1'b0;
        if (mode_chg || bus.mode) begin
            sel_cnt_d = '0;
        end else if (bus.en) begin
            if (sel_cnt_q == SEL_TERM) begin
                sel_cnt_d = '0;
                sel_tog   = 1'b1;
            end else begin
                sel_cnt_d = sel_cnt_q + 1'b1;
            end
        end
        // A debounced press still counts on a mode-change edge if the new mode is manual.
        if (bus.mode && db_rise) begin
            sel_tog = 1'b1;
        end
        sel_d = sel_q ^ sel_tog;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            db_cnt_q      <= '0;
            db_q          <= 1'b0;
            db_dly_q      <= 1'b0;
            sel_cnt_q     <= '0;
            mode_q        <= 1'b0;
            sel_q         <= 1'b0;
            sel_changed_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            db_cnt_q      <= db_cnt_d;
            db_q          <= db_d;
            db_dly_q      <= db_q;
            sel_cnt_q     <= sel_cnt_d;
            mode_q        <= bus.mode;
            sel_q         <= sel_d;
            sel_changed_q <= sel_tog;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.sel_changed = sel_changed_q;
endmodule

// File: tb/tb_mux_stim_gen.sv
// Scoreboard bench: scenarios queue the expected output changes, a monitor matches every observed change.
module tb_mux_stim_gen;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;

    typedef struct {
        int         edge_n;
        logic [3:0] vec;
    } ev_t;

    ev_t sb_q[$];
    int  ta[$];
    int  tb[$];
    int  ts[$];

    mux_stim_gen_if sif ();

    mux_stim_gen dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [3:0] outs();
        return {sif.in_a, sif.in_b, sif.sel, sif.sel_changed};
    endfunction

    function automatic bit has(input int q[$], input int e);
        foreach (q[i]) if (q[i] == e) return 1'b1;
        return 1'b0;
    endfunction

    // Expands hand-listed toggle edges into the sequence of output changes.
    task automatic build_expect(input int n);
        logic a, b, s, sc;
        logic [3:0] last, v;
        ev_t ev;
        a = 0; b = 0; s = 0; sc = 0; last = '0;
        for (int e = 1; e <= n; e++) begin
            if (has(ta, e)) a = ~a;
            if (has(tb, e)) b = ~b;
            sc = has(ts, e);
            if (sc) s = ~s;
            v = {a, b, s, sc};
            if (v != last) begin
                ev.edge_n = e;
                ev.vec    = v;
                sb_q.push_back(ev);
                last = v;
            end
        end
    endtask

    initial begin : monitor
        logic [3:0] prev, cur;
        ev_t ev;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = outs();
            if (!rst_n) begin
                prev = cur;
            end else if (cur != prev) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL unexpected_change: edge %0d outs %b, required no change from %b", cyc, cur, prev);
                end else begin
                    ev = sb_q.pop_front();
                    if (ev.edge_n == cyc && ev.vec == cur)
                        n_pass++;
                    else
                        $display("FAIL out_change: edge %0d outs %b, required edge %0d outs %b", cyc, cur, ev.edge_n, ev.vec);
                end
                prev = cur;
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, required %b", name, act, req);
    endtask

    task automatic check_empty(input string name);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL %s: %0d expected changes never seen, next at edge %0d outs %b", name, sb_q.size(), sb_q[0].edge_n, sb_q[0].vec);
            sb_q.delete();
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 4'b0000);
        ta.delete(); tb.delete(); ts.delete();
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        sif.en      = 1'b1;
        sif.mode    = 1'b0;
        sif.btn_raw = 1'b0;

        // S1: free-running defaults
        do_reset();
        for (int k = 10; k <= 400; k += 10) ta.push_back(k);
        for (int k = 50; k <= 400; k += 50) tb.push_back(k);
        ts.push_back(200); ts.push_back(400);
        build_expect(405);
        wait_cyc(407);
        check_empty("s1_defaults");

        // S2: en low for 30 edges (26..55)
        do_reset();
        ta = '{10, 20, 60, 70, 80, 90, 100};
        tb = '{80};
        build_expect(100);
        wait_cyc(25);  sif.en = 1'b0;
        wait_cyc(55);  sif.en = 1'b1;
        wait_cyc(102);
        check_empty("s2_enable_hold");

        // S3: clean press in manual mode, first sampled at edge 5
        sif.en = 1'b0; sif.mode = 1'b1;
        do_reset();
        ts = '{23};
        build_expect(80);
        wait_cyc(4);   sif.btn_raw = 1'b1;
        wait_cyc(34);  sif.btn_raw = 1'b0;
        wait_cyc(82);
        check_empty("s3_clean_press");
        check("s3_sel_held", outs(), 4'b0010);

        // S4: bouncing button never accepted
        do_reset();
        build_expect(100);
        wait_cyc(4);
        for (int i = 0; i < 40; i++) begin
            sif.btn_raw = ((i / 3) % 2 == 0);
            wait_cyc(5 + i);
        end
        sif.btn_raw = 1'b0;
        wait_cyc(102);
        check_empty("s4_bounce");
        check("s4_sel_low", outs(), 4'b0000);

        // S5: mode change on the SEL terminal edge, then a press, then back to auto
        sif.en = 1'b1; sif.mode = 1'b0;
        do_reset();
        for (int k = 10; k <= 445; k += 10) ta.push_back(k);
        for (int k = 50; k <= 445; k += 50) tb.push_back(k);
        ts = '{228, 440};
        build_expect(445);
        wait_cyc(199); sif.mode = 1'b1;
        wait_cyc(209); sif.btn_raw = 1'b1;
        wait_cyc(229); sif.btn_raw = 1'b0;
        wait_cyc(239); sif.mode = 1'b0;
        wait_cyc(447);
        check_empty("s5_mode_change");

        // S6: asynchronous reset mid-count
        do_reset();
        ta = '{10};
        build_expect(15);
        wait_cyc(15);
        check_empty("s6_pre_reset");
        check("s6_pre_reset_outs", outs(), 4'b1000);
        #2 rst_n = 1'b0;
        #1 check("s6_async_clear", outs(), 4'b0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ta = '{10, 20};
        build_expect(25);
        wait_cyc(27);
        check_empty("s6_restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
